// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the default baud
// divisors for 115200 baud from a 100 MHz clock.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int unsigned DEF_CLOCKS_PER_BAUD = 868;
    localparam int unsigned DEF_HALF_PER_BAUD   = 434;

endpackage

// File: rtl/tx_uart_baud_tick.sv
// Bit-period timer: loads CLOCKS_PER_BAUD-1, counts down while enabled and
// flags a bit boundary when the count is zero, reloading on that cycle.
module baud_tick #(
    parameter int unsigned TIMER_BITS      = 10,
    parameter int unsigned CLOCKS_PER_BAUD = 868
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_tick_c
);

    localparam logic [TIMER_BITS-1:0] RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);

    logic [TIMER_BITS-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load || (i_en && (r_count == '0))) begin
            r_count <= RELOAD;
        end else if (i_en) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tick_c = (r_count == '0);

endmodule

// File: rtl/tx_uart.sv
// UART transmitter: takes one word per valid/ready handshake and sends
// start, LSB-first data, optional parity and 1-2 stop bits on a registered line.
module tx_uart
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned TIMER_BITS      = 10,
    parameter int unsigned CLOCKS_PER_BAUD = DEF_CLOCKS_PER_BAUD,
    parameter int unsigned PARITY_EN       = 0,
    parameter int unsigned PARITY_ODD      = 0,
    parameter int unsigned STOP_BITS       = 1
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out_ready,
    output logic                 out_busy,
    output logic                 uart_rxd_out
);

    localparam int unsigned         IDX_W     = 4;
    localparam logic [IDX_W-1:0]    LAST_BIT  = IDX_W'(DATA_BITS - 1);
    localparam logic                ODD_BIT   = (PARITY_ODD != 0);
    localparam logic                LAST_STOP = (STOP_BITS == 2);

    tx_state_t            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_line;
    logic                 w_tick;
    logic                 w_accept;

    assign w_accept = (r_state == IDLE) && in_valid && r_ready;

    baud_tick #(
        .TIMER_BITS      (TIMER_BITS),
        .CLOCKS_PER_BAUD (CLOCKS_PER_BAUD)
    ) u_baud (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_load   (w_accept),
        .i_en     (r_busy),
        .o_tick_c (w_tick)
    );

    // Line value for the next bit is registered on the boundary that enters it.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_line     <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift  <= in_data;
                        r_parity <= (^in_data) ^ ODD_BIT;
                        r_state  <= START;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_line   <= 1'b0;
                    end else begin
                        r_ready  <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state   <= DATA;
                        r_line    <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                r_state <= PARITY;
                                r_line  <= r_parity;
                            end else begin
                                r_state    <= STOP;
                                r_line     <= 1'b1;
                                r_stop_idx <= 1'b0;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_line    <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_state    <= STOP;
                        r_line     <= 1'b1;
                        r_stop_idx <= 1'b0;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_stop_idx == LAST_STOP) begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_line  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_ready    = r_ready;
    assign out_busy     = r_busy;
    assign uart_rxd_out = r_line;

endmodule

// File: tb/tb_tx_uart.sv
// Directed bench for tx_uart: four instances (plain, odd parity, even parity,
// two stop bits) at 4 clocks per bit, line checked every cycle.
module tb_tx_uart;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [3:0] in_valid;
    logic [7:0] in_data [4];
    wire  [3:0] ready;
    wire  [3:0] busy;
    wire  [3:0] line;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tx_uart #(.CLOCKS_PER_BAUD(CPB)) u0 (
        .clk(clk), .i_reset(i_reset), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .out_ready(ready[0]), .out_busy(busy[0]), .uart_rxd_out(line[0]));
    tx_uart #(.CLOCKS_PER_BAUD(CPB), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
        .clk(clk), .i_reset(i_reset), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .out_ready(ready[1]), .out_busy(busy[1]), .uart_rxd_out(line[1]));
    tx_uart #(.CLOCKS_PER_BAUD(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u2 (
        .clk(clk), .i_reset(i_reset), .in_valid(in_valid[2]), .in_data(in_data[2]),
        .out_ready(ready[2]), .out_busy(busy[2]), .uart_rxd_out(line[2]));
    tx_uart #(.CLOCKS_PER_BAUD(CPB), .STOP_BITS(2)) u3 (
        .clk(clk), .i_reset(i_reset), .in_valid(in_valid[3]), .in_data(in_data[3]),
        .out_ready(ready[3]), .out_busy(busy[3]), .uart_rxd_out(line[3]));

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level for bit slot idx of a frame (0 = start bit).
    function automatic logic exp_bit(input logic [7:0] w, input logic par_en,
                                     input logic par_bit, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return w[idx-1];
        if (par_en && idx == 9) return par_bit;
        return 1'b1;
    endfunction

    task automatic wait_ready(input int k);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ready[k]) break;
        end
        chk_eq("ready_wait", 32'(ready[k]), 1);
    endtask

    task automatic run_frame(input int k, input logic [7:0] w, input logic par_en,
                             input logic par_bit, input int stops, input logic disturb);
        int len;
        len = (9 + int'(par_en) + stops) * CPB;
        wait_ready(k);
        in_data[k]  = w;
        in_valid[k] = 1'b1;
        @(posedge clk);
        #1 in_valid[k] = 1'b0;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            chk_eq("line", 32'(line[k]), 32'(exp_bit(w, par_en, par_bit, (c - 1) / CPB)));
            chk_eq("busy", 32'(busy[k]), 1);
            chk_eq("ready_low", 32'(ready[k]), 0);
            if (disturb) begin
                if (c == 10) in_data[k] = ~w;
                if (c == 20) in_valid[k] = 1'b1;
                if (c == 21) in_valid[k] = 1'b0;
            end
        end
        @(negedge clk);
        chk_eq("ready_after", 32'(ready[k]), 1);
        chk_eq("busy_after", 32'(busy[k]), 0);
        chk_eq("line_after", 32'(line[k]), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  t1, t2, nready;
        logic pb;
        logic expl;

        i_reset  = 1'b1;
        in_valid = '0;
        for (int i = 0; i < 4; i++) in_data[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_line", 32'(line), 32'hF);
        chk_eq("rst_ready", 32'(ready), 0);
        chk_eq("rst_busy", 32'(busy), 0);
        i_reset = 1'b0;
        @(negedge clk);
        chk_eq("ready_rise", 32'(ready), 32'hF);

        // 0x55, no parity, one stop bit
        run_frame(0, 8'h55, 1'b0, 1'b0, 1, 1'b0);

        // Back-to-back with in_valid held high
        wait_ready(0);
        in_data[0]  = 8'hA3;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_data[0] = 8'h0F;
        t1 = -1; t2 = -1; nready = 0; pb = 1'b0;
        for (int c = 1; c <= 82; c++) begin
            @(negedge clk);
            if (busy[0] && !pb) begin
                if (t1 < 0) t1 = c;
                else if (t2 < 0) t2 = c;
            end
            pb = busy[0];
            if (c <= 81 && ready[0]) nready++;
            if (c <= 40)      expl = exp_bit(8'hA3, 1'b0, 1'b0, (c - 1) / CPB);
            else if (c == 41) expl = 1'b1;
            else if (c <= 81) expl = exp_bit(8'h0F, 1'b0, 1'b0, (c - 42) / CPB);
            else              expl = 1'b1;
            chk_eq("b2b_line", 32'(line[0]), 32'(expl));
            if (c == 41) begin
                @(posedge clk);
                #1 in_valid[0] = 1'b0;
            end
        end
        chk_eq("start_spacing", 32'(t2 - t1), 41);
        chk_eq("ready_gap", 32'(nready), 1);
        chk_eq("b2b_ready_end", 32'(ready[0]), 1);

        // Parity: 0x07 has three ones -> odd gives 0, even gives 1
        run_frame(1, 8'h07, 1'b1, 1'b0, 1, 1'b0);
        run_frame(2, 8'h07, 1'b1, 1'b1, 1, 1'b0);

        // Two stop bits
        run_frame(3, 8'hFF, 1'b0, 1'b0, 2, 1'b0);

        // Reset during data bit 3 of 0x00
        wait_ready(0);
        in_data[0]  = 8'h00;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        for (int c = 1; c <= 18; c++) @(negedge clk);
        chk_eq("pre_rst_line", 32'(line[0]), 0);
        i_reset = 1'b1;
        @(negedge clk);
        chk_eq("abort_line", 32'(line[0]), 1);
        chk_eq("abort_busy", 32'(busy[0]), 0);
        chk_eq("abort_ready", 32'(ready[0]), 0);
        i_reset = 1'b0;
        @(negedge clk);
        chk_eq("post_rst_ready", 32'(ready[0]), 1);
        chk_eq("post_rst_line", 32'(line[0]), 1);
        run_frame(0, 8'h81, 1'b0, 1'b0, 1, 1'b0);

        // in_data change and in_valid pulse while busy
        run_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1);
        repeat (20) begin
            @(negedge clk);
            chk_eq("no_extra_busy", 32'(busy[0]), 0);
            chk_eq("no_extra_line", 32'(line[0]), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
